// File: rtl/fetch_stage.sv
// IF stage: owns the PC and the IF/ID register, and fetches from a req/ready instruction memory.
// A one-entry skid buffer holds a fetch that returns while ID is stalled.
module fetch_stage #(
  parameter logic [31:0] PC_RESET  = 32'h0000_3000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        PCWr,
  input  logic        IFIDWrite,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] PC,
  output logic [31:0] IF_ID_PC,
  output logic [31:0] IF_ID_PC4,
  output logic [31:0] IF_ID_Instr,
  output logic        IF_ID_Valid
);

  localparam int unsigned XLEN = 32;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_HELD = 2'd1,
    S_DROP = 2'd2
  } state_t;

  state_t            state_q;
  logic [XLEN-1:0]   pc_q;
  logic [XLEN-1:0]   fetch_addr_q;
  logic [XLEN-1:0]   hold_instr_q;
  logic [XLEN-1:0]   hold_pc_q;
  logic [XLEN-1:0]   ifid_pc_q;
  logic [XLEN-1:0]   ifid_pc4_q;
  logic [XLEN-1:0]   ifid_instr_q;
  logic              ifid_valid_q;

  logic              advance;
  logic [XLEN-1:0]   tgt_pc;
  logic              deliver;
  logic [XLEN-1:0]   deliver_pc;
  logic [XLEN-1:0]   deliver_instr;
  logic [XLEN-1:0]   drop_pc;

  assign advance = PCWr & IFIDWrite;
  assign tgt_pc  = redirect_pc & ~XLEN'(3);

  // Instruction offered to IF/ID this cycle: from memory in S_REQ, from the skid buffer in S_HELD.
  always_comb begin
    deliver       = 1'b0;
    deliver_pc    = fetch_addr_q;
    deliver_instr = imem_rdata;
    drop_pc       = (redirect && advance) ? tgt_pc : pc_q;
    if (state_q == S_REQ && imem_ready) begin
      deliver = 1'b1;
    end else if (state_q == S_HELD) begin
      deliver       = 1'b1;
      deliver_pc    = hold_pc_q;
      deliver_instr = hold_instr_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_REQ;
      pc_q         <= PC_RESET;
      fetch_addr_q <= PC_RESET;
      hold_instr_q <= NOP_INSTR;
      hold_pc_q    <= '0;
      ifid_pc_q    <= '0;
      ifid_pc4_q   <= XLEN'(4);
      ifid_instr_q <= NOP_INSTR;
      ifid_valid_q <= 1'b0;
    end else begin
      // IF/ID: redirect flushes the wrong-path slot, otherwise load or bubble.
      if (IFIDWrite) begin
        if (redirect) begin
          ifid_instr_q <= NOP_INSTR;
          ifid_valid_q <= 1'b0;
        end else if (deliver) begin
          ifid_pc_q    <= deliver_pc;
          ifid_pc4_q   <= deliver_pc + XLEN'(4);
          ifid_instr_q <= deliver_instr;
          ifid_valid_q <= 1'b1;
        end else begin
          ifid_instr_q <= NOP_INSTR;
          ifid_valid_q <= 1'b0;
        end
      end

      case (state_q)
        S_REQ: begin
          if (imem_ready) begin
            if (advance) begin
              if (redirect) begin
                pc_q         <= tgt_pc;
                fetch_addr_q <= tgt_pc;
              end else begin
                pc_q         <= fetch_addr_q + XLEN'(4);
                fetch_addr_q <= fetch_addr_q + XLEN'(4);
              end
            end else begin
              hold_instr_q <= imem_rdata;
              hold_pc_q    <= fetch_addr_q;
              state_q      <= S_HELD;
            end
          end else if (redirect && advance) begin
            pc_q    <= tgt_pc;
            state_q <= S_DROP;
          end
        end
        S_HELD: begin
          if (advance) begin
            if (redirect) begin
              pc_q         <= tgt_pc;
              fetch_addr_q <= tgt_pc;
            end else begin
              pc_q         <= hold_pc_q + XLEN'(4);
              fetch_addr_q <= hold_pc_q + XLEN'(4);
            end
            state_q <= S_REQ;
          end
        end
        S_DROP: begin
          // Old request must complete before the redirected fetch can be issued.
          pc_q <= drop_pc;
          if (imem_ready) begin
            fetch_addr_q <= drop_pc;
            state_q      <= S_REQ;
          end
        end
        default: state_q <= S_REQ;
      endcase
    end
  end

  assign imem_req    = (state_q != S_HELD) && !rst;
  assign imem_addr   = fetch_addr_q;
  assign PC          = pc_q;
  assign IF_ID_PC    = ifid_pc_q;
  assign IF_ID_PC4   = ifid_pc4_q;
  assign IF_ID_Instr = ifid_instr_q;
  assign IF_ID_Valid = ifid_valid_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: directed vector table, hand-written redirect/reset/wrap sequences,
// then random stalls/redirects/latencies against a queue-based reference model.
module tb_fetch_stage;

  localparam logic [31:0] KEY = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        rst, PCWr, IFIDWrite, redirect;
  logic [31:0] redirect_pc;
  logic        imem_req, imem_ready;
  logic [31:0] imem_addr, imem_rdata;
  logic [31:0] PC, IF_ID_PC, IF_ID_PC4, IF_ID_Instr;
  logic        IF_ID_Valid;

  fetch_stage dut (
    .clk(clk), .rst(rst), .PCWr(PCWr), .IFIDWrite(IFIDWrite),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .PC(PC), .IF_ID_PC(IF_ID_PC), .IF_ID_PC4(IF_ID_PC4),
    .IF_ID_Instr(IF_ID_Instr), .IF_ID_Valid(IF_ID_Valid)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Memory model: ready once the request has been waiting cur_lat cycles.
  int unsigned wcnt = 0;
  int unsigned cur_lat = 0;
  bit          rand_lat = 1'b0;
  bit          req_at_edge;

  // Reference model: architectural PC, outstanding fetch, drop flag, skid queue, IF/ID contents.
  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } slot_t;
  slot_t       skid[$];
  logic [31:0] m_pc, m_req_addr, m_ifpc, m_ifpc4, m_instr;
  bit          m_req_on, m_drop, m_valid;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return a ^ KEY;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    bit          adv, got, dlv;
    logic [31:0] rp, dpc, dins;
    adv = PCWr & IFIDWrite;
    rp  = {redirect_pc[31:2], 2'b00};
    got = m_req_on && imem_ready;
    if (rst) begin
      m_pc = 32'h3000; m_req_addr = 32'h3000; m_req_on = 1; m_drop = 0;
      skid.delete();
      m_ifpc = 0; m_ifpc4 = 4; m_instr = 0; m_valid = 0;
      return;
    end
    dlv = 0; dpc = 0; dins = 0;
    if (skid.size() > 0) begin
      dlv = 1; dpc = skid[0].pc; dins = skid[0].instr;
    end else if (got && !m_drop) begin
      dlv = 1; dpc = m_req_addr; dins = mem(m_req_addr);
    end
    if (IFIDWrite) begin
      if (redirect) begin
        m_instr = 0; m_valid = 0;
      end else if (dlv) begin
        m_ifpc = dpc; m_ifpc4 = dpc + 4; m_instr = dins; m_valid = 1;
      end else begin
        m_instr = 0; m_valid = 0;
      end
    end
    if (skid.size() > 0) begin
      if (adv) begin
        void'(skid.pop_front());
        m_pc = redirect ? rp : dpc + 4;
        m_req_on = 1; m_req_addr = m_pc;
      end
    end else if (m_drop) begin
      if (adv && redirect) m_pc = rp;
      if (got) begin m_drop = 0; m_req_addr = m_pc; end
    end else if (got) begin
      if (adv) begin
        m_pc = redirect ? rp : m_req_addr + 4;
        m_req_addr = m_pc;
      end else begin
        skid.push_back('{m_req_addr, mem(m_req_addr)});
        m_req_on = 0;
      end
    end else if (adv && redirect) begin
      m_pc = rp; m_drop = 1;
    end
  endtask

  task automatic check_model();
    assert (PCWr == IFIDWrite);
    chk("pc", PC, m_pc);
    chk("imem_req", 32'(imem_req), 32'(m_req_on && !rst));
    if (m_req_on && !rst) chk("imem_addr", imem_addr, m_req_addr);
    chk("ifid_pc", IF_ID_PC, m_ifpc);
    chk("ifid_pc4", IF_ID_PC4, m_ifpc4);
    chk("ifid_instr", IF_ID_Instr, m_instr);
    chk("ifid_valid", 32'(IF_ID_Valid), 32'(m_valid));
  endtask

  // One clock: drive inputs, answer memory, advance model, clock, check.
  task automatic cycle(input bit r, input bit a, input bit rd, input logic [31:0] rp);
    rst = r; PCWr = a; IFIDWrite = a; redirect = rd; redirect_pc = rp;
    #1;
    imem_ready  = imem_req && (wcnt >= cur_lat);
    imem_rdata  = mem(imem_addr);
    req_at_edge = imem_req;
    model_step();
    @(posedge clk);
    #1;
    if (r || (req_at_edge && imem_ready)) begin
      wcnt = 0;
      if (rand_lat) cur_lat = $urandom_range(0, 3);
    end else if (req_at_edge) begin
      wcnt++;
    end
    check_model();
  endtask

  typedef struct {
    bit          r, a, rd;
    logic [31:0] rp;
    logic [31:0] exp_pc, exp_ifpc, exp_instr;
    bit          exp_valid, exp_req;
  } vec_t;

  vec_t vecs[9];

  initial begin
    rst = 1; PCWr = 1; IFIDWrite = 1; redirect = 0; redirect_pc = 0;
    imem_ready = 0; imem_rdata = 0;

    vecs[0] = '{1, 1, 0, 32'h0,    32'h3000, 32'h0,    32'h0,        0, 0};
    vecs[1] = '{0, 1, 0, 32'h0,    32'h3004, 32'h3000, 32'hA5A53000, 1, 1};
    vecs[2] = '{0, 1, 0, 32'h0,    32'h3008, 32'h3004, 32'hA5A53004, 1, 1};
    vecs[3] = '{0, 0, 0, 32'h0,    32'h3008, 32'h3004, 32'hA5A53004, 1, 0};
    vecs[4] = '{0, 0, 0, 32'h0,    32'h3008, 32'h3004, 32'hA5A53004, 1, 0};
    vecs[5] = '{0, 1, 0, 32'h0,    32'h300C, 32'h3008, 32'hA5A53008, 1, 1};
    vecs[6] = '{0, 1, 0, 32'h0,    32'h3010, 32'h300C, 32'hA5A5300C, 1, 1};
    vecs[7] = '{0, 1, 1, 32'h3043, 32'h3040, 32'h300C, 32'h0,        0, 1};
    vecs[8] = '{0, 1, 0, 32'h0,    32'h3044, 32'h3040, 32'hA5A53040, 1, 1};

    cur_lat = 0;
    for (int i = 0; i < 9; i++) begin
      cycle(vecs[i].r, vecs[i].a, vecs[i].rd, vecs[i].rp);
      chk($sformatf("vec%0d_pc", i), PC, vecs[i].exp_pc);
      chk($sformatf("vec%0d_ifpc", i), IF_ID_PC, vecs[i].exp_ifpc);
      chk($sformatf("vec%0d_instr", i), IF_ID_Instr, vecs[i].exp_instr);
      chk($sformatf("vec%0d_valid", i), 32'(IF_ID_Valid), 32'(vecs[i].exp_valid));
      chk($sformatf("vec%0d_req", i), 32'(imem_req), 32'(vecs[i].exp_req));
    end

    // Redirect during a slow fetch of 3008: request held, data dropped, refetch at 3040.
    cycle(1, 1, 0, 0);
    cycle(0, 1, 0, 0);
    cycle(0, 1, 0, 0);
    cur_lat = 2;
    cycle(0, 1, 1, 32'h3040);
    chk("drop_addr0", imem_addr, 32'h3008);
    chk("drop_pc", PC, 32'h3040);
    for (int i = 0; i < 2; i++) begin
      cycle(0, 1, 0, 0);
      chk("drop_valid", 32'(IF_ID_Valid && IF_ID_PC == 32'h3008), 32'h0);
    end
    chk("refetch_addr", imem_addr, 32'h3040);
    cur_lat = 0;
    cycle(0, 1, 0, 0);
    chk("refetch_ifpc", IF_ID_PC, 32'h3040);
    chk("refetch_valid", 32'(IF_ID_Valid), 32'h1);

    // Reset while a dropped request is outstanding.
    cycle(0, 1, 0, 0);
    cur_lat = 3;
    cycle(0, 1, 1, 32'h3080);
    cycle(1, 1, 0, 0);
    chk("rst_drop_pc", PC, 32'h3000);
    chk("rst_drop_req", 32'(imem_req), 32'h0);
    chk("rst_drop_valid", 32'(IF_ID_Valid), 32'h0);
    cur_lat = 0;
    cycle(0, 1, 0, 0);
    chk("restart_ifpc", IF_ID_PC, 32'h3000);
    chk("restart_pc", PC, 32'h3004);

    // Sequential fetch across the top of the address space.
    cycle(0, 1, 1, 32'hFFFF_FFFE);
    chk("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    cycle(0, 1, 0, 0);
    chk("wrap_pc", PC, 32'h0);
    chk("wrap_pc4", IF_ID_PC4, 32'h0);

    // Random stalls, redirects, latencies and occasional resets.
    rand_lat = 1;
    cur_lat = $urandom_range(0, 3);
    for (int n = 0; n < 3000; n++) begin
      cycle($urandom_range(0, 99) == 0, $urandom_range(0, 9) < 7,
            $urandom_range(0, 4) == 0, $urandom);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
